// File: rtl/paddle_engine_pkg.sv
// Shared types and constants for the paddle engine: FSM states, position width,
// framebuffer defaults, default key codes and the cell address helper.
package paddle_engine_pkg;

  localparam int POS_W = 6;
  localparam int KEY_W = 8;

  localparam logic [15:0] DEF_FB_BASE     = 16'hA000;
  localparam logic [15:0] DEF_CLEAR_WORDS = 16'h0500;
  localparam logic [15:0] DEF_PADDLE_WORD = 16'h3F00;
  localparam int          DEF_ROW_STRIDE  = 64;

  localparam logic [KEY_W-1:0] KEY_P0_UP = 8'h77;
  localparam logic [KEY_W-1:0] KEY_P0_DN = 8'h73;
  localparam logic [KEY_W-1:0] KEY_P1_UP = 8'h69;
  localparam logic [KEY_W-1:0] KEY_P1_DN = 8'h6B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_GREQ,
    S_CLEAR,
    S_DRAWP,
    S_DONE
  } state_t;

  // All arithmetic is 16 bits and wraps, matching the memory controller's address space.
  function automatic logic [15:0] cell_addr(input logic [15:0]      base,
                                            input logic [POS_W-1:0] row,
                                            input logic [15:0]      stride,
                                            input logic [POS_W-1:0] col);
    return base + 16'(row) * stride + 16'(col);
  endfunction

endpackage

// File: rtl/paddle_engine_if.sv
// Key, GPU handshake and memory write bus between the paddle engine (slave)
// and its surroundings (master: keyboard front end, GPU arbiter, memory controller).
interface paddle_engine_if;
  import paddle_engine_pkg::*;

  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             key_ready;
  logic             gpu_ready;
  logic             gpu_request;
  logic             gpu_draw;
  logic             mem_enable;
  logic             mem_write;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_data_w;

  modport master (
    output key_valid, key_code, gpu_ready,
    input  key_ready, gpu_request, gpu_draw, mem_enable, mem_write, mem_addr, mem_data_w
  );

  modport slave (
    input  key_valid, key_code, gpu_ready,
    output key_ready, gpu_request, gpu_draw, mem_enable, mem_write, mem_addr, mem_data_w
  );

endinterface

// File: rtl/paddle_engine_key_fifo.sv
// key_fifo: generic synchronous FIFO with first-word fall-through read data,
// occupancy count and full/empty flags; push ignored when full, pop ignored when empty.
module key_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push, w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/paddle_engine.sv
// paddle_engine: key FIFO -> per-frame paddle moves -> framebuffer clear and paddle draw.
// Optional PADDLE_ENGINE_DROP_CNT_EN adds o_drop_count (saturating dropped keys + lost ticks).
//
// state   | meaning
// S_IDLE  | waiting for a frame tick (fresh or pending)
// S_DRAIN | popping the keys queued before the tick, moving paddles
// S_GREQ  | requesting the framebuffer, waiting for gpu_ready
// S_CLEAR | zeroing CLEAR_WORDS words from FB_BASE
// S_DRAWP | writing PADDLE_LEN cells per paddle, top row first
// S_DONE  | one-cycle gpu_draw pulse
module paddle_engine
  import paddle_engine_pkg::*;
#(
  parameter int                          N_PADDLES   = 2,
  parameter int                          FIELD_ROWS  = 18,
  parameter int                          PADDLE_LEN  = 4,
  parameter int                          KEYQ_DEPTH  = 16,
  parameter logic [15:0]                 FB_BASE     = DEF_FB_BASE,
  parameter int                          ROW_STRIDE  = DEF_ROW_STRIDE,
  parameter logic [15:0]                 CLEAR_WORDS = DEF_CLEAR_WORDS,
  parameter logic [N_PADDLES*KEY_W-1:0]  UP_KEYS     = {KEY_P1_UP, KEY_P0_UP},
  parameter logic [N_PADDLES*KEY_W-1:0]  DOWN_KEYS   = {KEY_P1_DN, KEY_P0_DN},
  parameter logic [N_PADDLES*POS_W-1:0]  COLS        = {6'd61, 6'd2},
  parameter logic [15:0]                 PADDLE_WORD = DEF_PADDLE_WORD
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_tick,
  paddle_engine_if.slave               bus,
  output logic                         o_busy,
  output logic                         o_overflow,
  output logic [N_PADDLES*POS_W-1:0]   o_paddle_pos
`ifdef PADDLE_ENGINE_DROP_CNT_EN
  ,
  output logic [7:0]                   o_drop_count
`endif
);

  localparam int                CNT_W     = $clog2(KEYQ_DEPTH) + 1;
  localparam int                PIDX_W    = (N_PADDLES > 1) ? $clog2(N_PADDLES) : 1;
  localparam logic [POS_W-1:0]  HALF      = POS_W'(PADDLE_LEN / 2);
  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(FIELD_ROWS - PADDLE_LEN / 2);
  localparam logic [POS_W-1:0]  POS_RST   = POS_W'(FIELD_ROWS / 2);
  localparam logic [15:0]       LEN_M1    = 16'(PADDLE_LEN - 1);
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(N_PADDLES - 1);

  state_t             r_state, w_state_nxt;
  logic               w_rst;
  logic               w_push, w_pop, w_full, w_empty;
  logic [KEY_W-1:0]   w_key;
  logic [CNT_W-1:0]   w_count, r_drain_left, w_drain_nxt;
  logic [15:0]        r_cnt, w_cnt_nxt;
  logic [PIDX_W-1:0]  r_pidx, w_pidx_nxt, w_p_first;
  logic               r_mem_en, w_mem_en_nxt;
  logic [15:0]        r_mem_addr, w_addr_nxt, r_mem_data, w_data_nxt;
  logic               r_gpu_req, r_gpu_draw;
  logic               r_tick_pend, r_overflow, w_key_drop, w_tick_lost;
  logic [POS_W-1:0]   r_pos [N_PADDLES];
  logic [POS_W-1:0]   w_off;
  logic [15:0]        w_addr_first, w_addr_cur;

  assign w_rst       = i_reset || !i_enable;
  assign w_push      = bus.key_valid && !w_full;
  assign w_pop       = (r_state == S_DRAIN) && (r_drain_left != '0) && !w_empty;
  assign w_key_drop  = bus.key_valid && w_full;
  assign w_tick_lost = i_tick && (r_state != S_IDLE) && r_tick_pend;

  key_fifo #(
    .DEPTH (KEYQ_DEPTH),
    .WIDTH (KEY_W)
  ) u_key_fifo (
    .i_clk   (i_clk),
    .i_rst   (w_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (bus.key_code),
    .o_rdata (w_key),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // First cell of the next paddle to draw, and the next row of the current paddle.
  always_comb begin
    w_p_first = '0;
    if (r_state == S_DRAWP && r_pidx != PIDX_LAST) w_p_first = r_pidx + 1'b1;
    w_off        = POS_W'(PADDLE_LEN) - r_cnt[POS_W-1:0];
    w_addr_first = cell_addr(FB_BASE, r_pos[w_p_first] - HALF, 16'(ROW_STRIDE),
                             COLS[w_p_first*POS_W +: POS_W]);
    w_addr_cur   = cell_addr(FB_BASE, r_pos[r_pidx] - HALF + w_off, 16'(ROW_STRIDE),
                             COLS[r_pidx*POS_W +: POS_W]);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pidx_nxt   = r_pidx;
    w_drain_nxt  = r_drain_left;
    w_mem_en_nxt = 1'b0;
    w_addr_nxt   = r_mem_addr;
    w_data_nxt   = r_mem_data;
    unique case (r_state)
      S_IDLE: begin
        if (i_tick || r_tick_pend) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = w_count;
        end
      end
      S_DRAIN: begin
        if (r_drain_left == '0) w_state_nxt = S_GREQ;
        else                    w_drain_nxt = r_drain_left - 1'b1;
      end
      S_GREQ: begin
        if (bus.gpu_ready) begin
          w_state_nxt  = S_CLEAR;
          w_mem_en_nxt = 1'b1;
          w_addr_nxt   = FB_BASE;
          w_data_nxt   = '0;
          w_cnt_nxt    = CLEAR_WORDS - 1'b1;
        end
      end
      S_CLEAR: begin
        w_mem_en_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = S_DRAWP;
          w_pidx_nxt  = '0;
          w_cnt_nxt   = LEN_M1;
          w_addr_nxt  = w_addr_first;
          w_data_nxt  = PADDLE_WORD;
        end else begin
          w_cnt_nxt  = r_cnt - 1'b1;
          w_addr_nxt = r_mem_addr + 1'b1;
          w_data_nxt = '0;
        end
      end
      S_DRAWP: begin
        if (r_cnt == '0) begin
          if (r_pidx == PIDX_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_mem_en_nxt = 1'b1;
            w_pidx_nxt   = w_p_first;
            w_cnt_nxt    = LEN_M1;
            w_addr_nxt   = w_addr_first;
            w_data_nxt   = PADDLE_WORD;
          end
        end else begin
          w_mem_en_nxt = 1'b1;
          w_cnt_nxt    = r_cnt - 1'b1;
          w_addr_nxt   = w_addr_cur;
          w_data_nxt   = PADDLE_WORD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pidx       <= '0;
      r_drain_left <= '0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_gpu_req    <= 1'b0;
      r_gpu_draw   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pidx       <= w_pidx_nxt;
      r_drain_left <= w_drain_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_mem_data   <= w_data_nxt;
      r_gpu_req    <= (w_state_nxt == S_GREQ) || (w_state_nxt == S_CLEAR) ||
                      (w_state_nxt == S_DRAWP);
      r_gpu_draw   <= (w_state_nxt == S_DONE);
    end
  end

  // Up wins over down when a key is bound to both on the same paddle.
  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      for (int i = 0; i < N_PADDLES; i++) r_pos[i] <= POS_RST;
    end else if (w_pop) begin
      for (int i = 0; i < N_PADDLES; i++) begin
        if (w_key == UP_KEYS[i*KEY_W +: KEY_W]) begin
          if (r_pos[i] > HALF) r_pos[i] <= r_pos[i] - 1'b1;
        end else if (w_key == DOWN_KEYS[i*KEY_W +: KEY_W]) begin
          if (r_pos[i] < POS_MAX) r_pos[i] <= r_pos[i] + 1'b1;
        end
      end
    end
  end

  // An IDLE cycle consumes the pending tick; a tick arriving in that same cycle stays pending.
  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      r_tick_pend <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_state == S_IDLE) r_tick_pend <= r_tick_pend && i_tick;
      else                   r_tick_pend <= r_tick_pend || i_tick;
      if (w_key_drop || w_tick_lost) r_overflow <= 1'b1;
    end
  end

`ifdef PADDLE_ENGINE_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic [8:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_cnt} + {8'd0, w_key_drop} + {8'd0, w_tick_lost};

  always_ff @(posedge i_clk) begin
    if (w_rst)              r_drop_cnt <= '0;
    else if (w_drop_sum[8]) r_drop_cnt <= 8'hFF;
    else                    r_drop_cnt <= w_drop_sum[7:0];
  end

  assign o_drop_count = r_drop_cnt;
`endif

  for (genvar g = 0; g < N_PADDLES; g++) begin : g_pos
    assign o_paddle_pos[g*POS_W +: POS_W] = r_pos[g];
  end

  assign bus.key_ready   = !w_full;
  assign bus.gpu_request = r_gpu_req;
  assign bus.gpu_draw    = r_gpu_draw;
  assign bus.mem_enable  = r_mem_en;
  assign bus.mem_write   = r_mem_en;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data_w  = r_mem_data;
  assign o_busy          = (r_state != S_IDLE);
  assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_paddle_engine.sv
// Directed bench for paddle_engine: frame contents and latency, key moves with
// saturation, FIFO overflow, GPU handshake stall, tick pending/loss, reset/enable abort.
module tb_paddle_engine;

  logic        clk = 1'b0;
  logic        reset, enable, tick;
  logic        busy, overflow;
  logic [11:0] paddle_pos;
`ifdef PADDLE_ENGINE_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  int          draws = 0;
  int          we_mismatch = 0;
  logic [15:0] wr_addr [$];
  logic [15:0] wr_data [$];

  localparam int FRAME_LAT = 1 + 1 + 1280 + 2 * 4 + 1;

  paddle_engine_if bus ();

  paddle_engine dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_tick       (tick),
    .bus          (bus),
    .o_busy       (busy),
    .o_overflow   (overflow),
    .o_paddle_pos (paddle_pos)
`ifdef PADDLE_ENGINE_DROP_CNT_EN
    ,
    .o_drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_enable) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data_w);
    end
    if (bus.gpu_draw) draws++;
    if (bus.mem_write !== bus.mem_enable) we_mismatch++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_wait(2);
    reset = 1'b0;
  endtask

  task automatic push_key(input logic [7:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    clk_wait(1);
    bus.key_valid = 1'b0;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    clk_wait(1);
    tick = 1'b0;
  endtask

  task automatic wait_draw(input int budget, inout int cyc);
    while (!bus.gpu_draw && cyc < budget) begin
      clk_wait(1);
      cyc++;
    end
    check_val("frame_done", 32'(bus.gpu_draw), 32'd1);
  endtask

  // cyc counts cycles from the tick cycle (0) to the gpu_draw cycle
  task automatic run_frame(output int cyc);
    tick_pulse();
    cyc = 1;
    wait_draw(4000, cyc);
  endtask

  initial begin
    int          cyc;
    int          bad;
    int          d0;
    logic [15:0] exp_pad [8];

    exp_pad = '{16'hA1C2, 16'hA202, 16'hA242, 16'hA282,
                16'hA1FD, 16'hA23D, 16'hA27D, 16'hA2BD};
    reset = 1'b1; enable = 1'b1; tick = 1'b0;
    bus.key_valid = 1'b0; bus.key_code = 8'h00; bus.gpu_ready = 1'b0;
    clk_wait(3);

    // reset state
    check_val("rst_key_ready", 32'(bus.key_ready), 32'd1);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_strobes", 32'({bus.mem_enable, bus.gpu_request, bus.gpu_draw}), 32'd0);
    check_val("rst_mem_bus", 32'({bus.mem_addr, bus.mem_data_w}), 32'd0);
    check_val("rst_pos", 32'(paddle_pos), 32'h249);
    reset = 1'b0;

    // empty frame: clear, paddles at rows 7..10, exact latency
    bus.gpu_ready = 1'b1;
    wr_addr.delete(); wr_data.delete();
    run_frame(cyc);
    check_val("lat_empty", 32'(cyc), 32'(FRAME_LAT));
    check_val("wr_count", 32'(wr_addr.size()), 32'd1288);
    bad = 0;
    for (int i = 0; i < 1280; i++)
      if (wr_addr[i] !== 16'(16'hA000 + i) || wr_data[i] !== 16'h0000) bad++;
    check_val("clear_writes_bad", 32'(bad), 32'd0);
    check_val("clear_last", 32'(wr_addr[1279]), 32'hA4FF);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("pad_addr%0d", i), 32'(wr_addr[1280+i]), 32'(exp_pad[i]));
      check_val($sformatf("pad_data%0d", i), 32'(wr_data[1280+i]), 32'h3F00);
    end
    clk_wait(1);
    check_val("draw_one_cycle", 32'({bus.gpu_draw, busy}), 32'd0);

    // paddle 0 up x10 saturates at 2
    for (int i = 0; i < 10; i++) push_key(8'h77);
    run_frame(cyc);
    check_val("pos_up_sat", 32'(paddle_pos), 32'h242);

    // mixed keys: p0 down x10, p1 up x3 down x1, one unmatched key
    for (int i = 0; i < 10; i++) push_key(8'h73);
    push_key(8'h69); push_key(8'h69); push_key(8'h41); push_key(8'h69); push_key(8'h6B);
    clk_wait(1);
    run_frame(cyc);
    check_val("lat_15keys", 32'(cyc), 32'(FRAME_LAT + 15));
    check_val("pos_mixed", 32'(paddle_pos), 32'h1CC);

    // p0 down x10 more saturates at 16; check moved cells
    for (int i = 0; i < 10; i++) push_key(8'h73);
    wr_addr.delete(); wr_data.delete();
    run_frame(cyc);
    check_val("pos_dn_sat", 32'(paddle_pos), 32'h1D0);
    check_val("p0_top_cell", 32'(wr_addr[1280]), 32'hA382);
    check_val("p0_bot_cell", 32'(wr_addr[1283]), 32'hA442);
    check_val("p1_top_cell", 32'(wr_addr[1284]), 32'hA17D);
    clk_wait(2);

    // FIFO overflow
    do_reset();
    for (int i = 0; i < 15; i++) push_key(8'h41);
    check_val("ready_at_15", 32'(bus.key_ready), 32'd1);
    push_key(8'h41);
    check_val("ready_at_16", 32'(bus.key_ready), 32'd0);
    check_val("ovf_before_drop", 32'(overflow), 32'd0);
    push_key(8'h77);
    check_val("ovf_after_drop", 32'(overflow), 32'd1);
`ifdef PADDLE_ENGINE_DROP_CNT_EN
    check_val("drop_count_1", 32'(drop_count), 32'd1);
`endif
    run_frame(cyc);
    check_val("lat_16keys", 32'(cyc), 32'(FRAME_LAT + 16));
    check_val("pos_after_ovf", 32'(paddle_pos), 32'h249);
    check_val("ready_after_drain", 32'(bus.key_ready), 32'd1);
    clk_wait(2);

    // GPU_READY held low 50 cycles after DRAIN
    do_reset();
    bus.gpu_ready = 1'b0;
    wr_addr.delete(); wr_data.delete();
    tick_pulse();
    clk_wait(1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.mem_enable || !bus.gpu_request || !busy) bad++;
      clk_wait(1);
    end
    check_val("stall_bad_cycles", 32'(bad), 32'd0);
    check_val("stall_no_writes", 32'(wr_addr.size()), 32'd0);
    bus.gpu_ready = 1'b1;
    cyc = 0;
    wait_draw(3000, cyc);
    check_val("stall_wr_count", 32'(wr_addr.size()), 32'd1288);
    clk_wait(2);

    // three ticks in one frame: one extra frame, one tick lost
    do_reset();
    d0 = draws;
    tick_pulse();
    clk_wait(5);
    tick_pulse();
    check_val("ovf_one_pending", 32'(overflow), 32'd0);
    clk_wait(5);
    tick_pulse();
    check_val("ovf_tick_lost", 32'(overflow), 32'd1);
`ifdef PADDLE_ENGINE_DROP_CNT_EN
    check_val("drop_count_tick", 32'(drop_count), 32'd1);
`endif
    clk_wait(3000);
    check_val("frames_run", 32'(draws - d0), 32'd2);
    check_val("idle_after", 32'(busy), 32'd0);

    // reset mid-CLEAR
    do_reset();
    push_key(8'h77); push_key(8'h77);
    tick_pulse();
    clk_wait(100);
    check_val("mid_clear_en", 32'({busy, bus.mem_enable, bus.gpu_request}), 32'h7);
    check_val("mid_clear_pos", 32'(paddle_pos), 32'h247);
    reset = 1'b1;
    clk_wait(1);
    check_val("abort_strobes", 32'({busy, bus.mem_enable, bus.gpu_request, bus.gpu_draw}), 32'd0);
    check_val("abort_pos", 32'(paddle_pos), 32'h249);
    reset = 1'b0;

    // ENABLE low mid-frame behaves as reset, next frame is normal
    tick_pulse();
    clk_wait(20);
    enable = 1'b0;
    clk_wait(1);
    check_val("disable_abort", 32'({busy, bus.mem_enable, bus.gpu_request}), 32'd0);
    enable = 1'b1;
    run_frame(cyc);
    check_val("lat_after_disable", 32'(cyc), 32'(FRAME_LAT));
    clk_wait(2);

    check_val("mem_write_eq_en", 32'(we_mismatch), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
